// File: rtl/phase_meas_pkg.sv
// phase_meas_pkg: shared types and defaults for the phase measurement block.
//   state_e  - measurement FSM states
//   *_DEF    - default parameter values for counter width, offset and timeout
//   sat_sub  - unsigned subtract clamped at zero
package phase_meas_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int PHOFFSET_DEF = 4;
  localparam int TIMEOUT_DEF  = 1023;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // 32-bit wide so any CNT_W up to 32 can share it; callers cast the result.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/phase_meas_if.sv
// phase_meas_if: measurement control inputs and result outputs.
//   enable, ref_in, dly_in             - driven by the master (firmware / bench)
//   raw_delay, meas_delay, underflow,
//   meas_valid, timeout, busy          - driven by the slave (phase_meas)
interface phase_meas_if
  import phase_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             enable;
  logic             ref_in;
  logic             dly_in;
  logic [CNT_W-1:0] raw_delay;
  logic [CNT_W-1:0] meas_delay;
  logic             underflow;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output enable, ref_in, dly_in,
    input  raw_delay, meas_delay, underflow, meas_valid, timeout, busy
  );

  modport slave (
    input  enable, ref_in, dly_in,
    output raw_delay, meas_delay, underflow, meas_valid, timeout, busy
  );
endinterface

// File: rtl/phase_meas_sync_edge_det.sv
// sync_edge_det: SYNC_STAGES-deep synchronizer followed by an any-edge detector.
//   Clk        in  clock
//   Reset      in  synchronous active-high reset (clears chain and history)
//   async_in   in  asynchronous input
//   edge_pulse out one-cycle registered pulse on any transition of the
//                  synchronized value
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic edge_pulse
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    // Registered so both inputs see identical, fixed latency to the FSM.
    edge_d = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_pulse = edge_q;
endmodule

// File: rtl/phase_meas.sv
// phase_meas: measures the Clk-cycle distance from a ref_in edge to the next
// dly_in edge and recovers the programmed phase delay (raw - PHOFFSET).
//   Clk    in  clock
//   Reset  in  synchronous active-high reset
//   bus    phase_meas_if.slave: enable/ref_in/dly_in in; raw_delay,
//          meas_delay, underflow, meas_valid, timeout, busy out
module phase_meas
  import phase_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PHOFFSET    = PHOFFSET_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  phase_meas_if.slave  bus
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PHO = CNT_W'(PHOFFSET);

  // Index 0 = ref, 1 = dly; same conditioning path so latency cancels.
  logic [1:0] async_in;
  logic [1:0] edge_det;
  logic       ref_edge, dly_edge;

  assign async_in = {bus.dly_in, bus.ref_in};

  for (genvar i = 0; i < 2; i++) begin : g_in
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sed (
      .Clk        (Clk),
      .Reset      (Reset),
      .async_in   (async_in[i]),
      .edge_pulse (edge_det[i])
    );
  end

  assign ref_edge = edge_det[0];
  assign dly_edge = edge_det[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] raw_q, raw_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             unf_q, unf_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;

  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    raw_d    = raw_q;
    meas_d   = meas_q;
    unf_d    = unf_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;
    load     = 1'b0;
    load_val = '0;

    unique case (state_q)
      IDLE: begin
        // A lone dly edge has no reference and is ignored.
        if (bus.enable && ref_edge) begin
          if (dly_edge) begin
            load     = 1'b1;
            load_val = '0;
          end else begin
            state_d = COUNT;
            cnt_d   = '0;
          end
        end
      end
      COUNT: begin
        cnt_d = cnt_inc;
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (dly_edge) begin
          load     = 1'b1;
          load_val = cnt_inc;
          // Coincident ref edge starts the next measurement immediately.
          if (ref_edge) cnt_d = '0;
          else          state_d = IDLE;
        end else if (ref_edge) begin
          cnt_d = '0;
        end else if (cnt_inc == TMO) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      raw_d   = load_val;
      meas_d  = CNT_W'(sat_sub(32'(load_val), 32'(PHOFFSET)));
      unf_d   = (load_val < PHO);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      raw_q   <= '0;
      meas_q  <= '0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      meas_q  <= meas_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.raw_delay  = raw_q;
  assign bus.meas_delay = meas_q;
  assign bus.underflow  = unf_q;
  assign bus.meas_valid = valid_q;
  assign bus.timeout    = tmo_q;
  assign bus.busy       = (state_q == COUNT);
endmodule

// File: tb/tb_phase_meas.sv
module tb_phase_meas;
  localparam int CNT_W    = 16;
  localparam int PHOFFSET = 4;
  localparam int TIMEOUT  = 1023;
  localparam int SYNC     = 2;
  localparam int LAT      = SYNC + 2; // input toggle to registered output

  typedef struct {
    logic [CNT_W-1:0] raw;
    logic [CNT_W-1:0] meas;
    logic             unf;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  phase_meas_if #(.CNT_W(CNT_W)) bus ();

  phase_meas #(
    .CNT_W(CNT_W), .PHOFFSET(PHOFFSET), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int   checks   = 0;
  int   failures = 0;
  int   nvalid   = 0;
  int   ntmo     = 0;
  exp_t sb[$];

  function automatic exp_t model(input int d);
    exp_t e;
    e.raw  = CNT_W'(d);
    e.meas = (d >= PHOFFSET) ? CNT_W'(d - PHOFFSET) : '0;
    e.unf  = (d < PHOFFSET);
    return e;
  endfunction

  // Scoreboard consumer: every meas_valid pops one expected result.
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      if (bus.meas_valid === 1'b1) begin
        exp_t e;
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_valid raw=%0d meas=%0d unf=%0b", bus.raw_delay, bus.meas_delay, bus.underflow);
        end else begin
          e = sb.pop_front();
          if (bus.raw_delay !== e.raw || bus.meas_delay !== e.meas || bus.underflow !== e.unf) begin
            failures++;
            $display("FAIL sb_result got raw=%0d meas=%0d unf=%0b want raw=%0d meas=%0d unf=%0b",
                     bus.raw_delay, bus.meas_delay, bus.underflow, e.raw, e.meas, e.unf);
          end
        end
      end
      if (bus.timeout === 1'b1) ntmo++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic toggle_ref();
    bus.ref_in = ~bus.ref_in;
  endtask

  task automatic toggle_dly();
    bus.dly_in = ~bus.dly_in;
  endtask

  // ref edge, then dly edge d cycles later; expected result queued.
  task automatic measure(input int d);
    toggle_ref();
    if (d > 0) tick(d);
    toggle_dly();
    sb.push_back(model(d));
    tick(LAT + 4);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.enable = 1'b0;
    bus.ref_in = 1'b0;
    bus.dly_in = 1'b0;
    tick(4);
    Reset = 1'b0;
    tick(1);
    checks++;
    if (bus.raw_delay !== 0 || bus.meas_delay !== 0 || bus.underflow !== 0 ||
        bus.meas_valid !== 0 || bus.timeout !== 0 || bus.busy !== 0) begin
      failures++;
      $display("FAIL reset_outputs got raw=%0d meas=%0d unf=%0b v=%0b t=%0b b=%0b want all 0",
               bus.raw_delay, bus.meas_delay, bus.underflow, bus.meas_valid, bus.timeout, bus.busy);
    end
    bus.enable = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int v0 = nvalid;
    toggle_ref();
    tick(17);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %0b want 1", bus.busy);
    end
    toggle_dly();
    sb.push_back(model(17));
    tick(LAT - 1);
    checks++;
    if (bus.meas_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency_early got valid=%0b want 0", bus.meas_valid);
    end
    tick(1);
    checks++;
    if (bus.meas_valid !== 1'b1 || bus.raw_delay !== 17 || bus.meas_delay !== 13 || bus.underflow !== 0) begin
      failures++;
      $display("FAIL basic_result got v=%0b raw=%0d meas=%0d unf=%0b want v=1 raw=17 meas=13 unf=0",
               bus.meas_valid, bus.raw_delay, bus.meas_delay, bus.underflow);
    end
    tick(6);
    checks++;
    if (nvalid - v0 != 1 || bus.busy !== 1'b0 || bus.raw_delay !== 17) begin
      failures++;
      $display("FAIL basic_single_pulse got pulses=%0d busy=%0b raw=%0d want 1 0 17", nvalid - v0, bus.busy, bus.raw_delay);
    end
  endtask

  task automatic test_small();
    measure(0);
    checks++;
    if (bus.raw_delay !== 0 || bus.meas_delay !== 0 || bus.underflow !== 1'b1) begin
      failures++;
      $display("FAIL zero_delay got raw=%0d meas=%0d unf=%0b want 0 0 1", bus.raw_delay, bus.meas_delay, bus.underflow);
    end
    measure(2);
    checks++;
    if (bus.raw_delay !== 2 || bus.meas_delay !== 0 || bus.underflow !== 1'b1) begin
      failures++;
      $display("FAIL small_delay got raw=%0d meas=%0d unf=%0b want 2 0 1", bus.raw_delay, bus.meas_delay, bus.underflow);
    end
    measure(PHOFFSET);
    checks++;
    if (bus.raw_delay !== PHOFFSET || bus.meas_delay !== 0 || bus.underflow !== 1'b0) begin
      failures++;
      $display("FAIL offset_boundary got raw=%0d meas=%0d unf=%0b want %0d 0 0", bus.raw_delay, bus.meas_delay, bus.underflow, PHOFFSET);
    end
  endtask

  task automatic test_free_run();
    int v0 = nvalid;
    for (int i = 0; i < 7; i++) begin
      int lag = (i < 4) ? 13 : 17;
      toggle_ref();
      tick(lag);
      toggle_dly();
      sb.push_back(model(lag));
      tick(200 - lag);
    end
    checks++;
    if (nvalid - v0 != 7 || bus.raw_delay !== 17) begin
      failures++;
      $display("FAIL free_run got pulses=%0d raw=%0d want 7 17", nvalid - v0, bus.raw_delay);
    end
  endtask

  task automatic test_timeout();
    int v0 = nvalid;
    int t0 = ntmo;
    int n = 0;
    bit seen = 0;
    logic [CNT_W-1:0] raw0 = bus.raw_delay;
    toggle_ref();
    while (!seen && n < TIMEOUT + 100) begin
      tick(1);
      n++;
      if (bus.timeout === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != TIMEOUT + LAT) begin
      failures++;
      $display("FAIL timeout_latency got seen=%0b cycles=%0d want 1 %0d", seen, n, TIMEOUT + LAT);
    end
    tick(2);
    checks++;
    if (bus.busy !== 1'b0 || bus.raw_delay !== raw0 || nvalid != v0 || ntmo - t0 != 1) begin
      failures++;
      $display("FAIL timeout_hold got busy=%0b raw=%0d valids=%0d tmos=%0d want 0 %0d 0 1",
               bus.busy, bus.raw_delay, nvalid - v0, ntmo - t0, raw0);
    end
  endtask

  task automatic test_restart();
    toggle_ref();
    tick(5);
    toggle_ref();
    tick(9);
    toggle_dly();
    sb.push_back(model(9));
    tick(LAT + 4);
    checks++;
    if (bus.raw_delay !== 9 || bus.meas_delay !== 5) begin
      failures++;
      $display("FAIL restart got raw=%0d meas=%0d want 9 5", bus.raw_delay, bus.meas_delay);
    end
  endtask

  task automatic test_back_to_back();
    toggle_ref();
    tick(6);
    toggle_ref();
    toggle_dly();
    sb.push_back(model(6));
    tick(LAT);
    checks++;
    if (bus.meas_valid !== 1'b1 || bus.busy !== 1'b1 || bus.raw_delay !== 6) begin
      failures++;
      $display("FAIL rearm got v=%0b busy=%0b raw=%0d want 1 1 6", bus.meas_valid, bus.busy, bus.raw_delay);
    end
    tick(10 - LAT);
    toggle_dly();
    sb.push_back(model(10));
    tick(LAT + 2);
    checks++;
    if (bus.raw_delay !== 10 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rearm_second got raw=%0d busy=%0b want 10 0", bus.raw_delay, bus.busy);
    end
  endtask

  task automatic test_abort();
    int v0 = nvalid;
    int t0 = ntmo;
    logic [CNT_W-1:0] raw0 = bus.raw_delay;
    toggle_ref();
    tick(LAT + 6);
    bus.enable = 1'b0;
    tick(3);
    checks++;
    if (bus.busy !== 1'b0 || nvalid != v0 || ntmo != t0 || bus.raw_delay !== raw0) begin
      failures++;
      $display("FAIL enable_abort got busy=%0b valids=%0d tmos=%0d raw=%0d want 0 0 0 %0d",
               bus.busy, nvalid - v0, ntmo - t0, bus.raw_delay, raw0);
    end
    bus.enable = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid();
    int v0 = nvalid;
    int t0 = ntmo;
    toggle_ref();
    tick(LAT + 6);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy got %0b want 1", bus.busy);
    end
    Reset = 1'b1;
    bus.ref_in = 1'b0;
    bus.dly_in = 1'b0;
    tick(3);
    Reset = 1'b0;
    tick(20);
    checks++;
    if (bus.busy !== 0 || bus.raw_delay !== 0 || bus.meas_delay !== 0 || bus.underflow !== 0 ||
        nvalid != v0 || ntmo != t0) begin
      failures++;
      $display("FAIL reset_mid got busy=%0b raw=%0d meas=%0d unf=%0b valids=%0d tmos=%0d want all 0",
               bus.busy, bus.raw_delay, bus.meas_delay, bus.underflow, nvalid - v0, ntmo - t0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_free_run();
    test_timeout();
    test_restart();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
